// File: rtl/spi_input_conditioner_if.sv
`default_nettype none
// ============================================================================
// Module      : spi_input_conditioner_if
// Description : Raw SPI pins in, conditioned levels and edge strobes out.
// Revision    : 1.0 - initial release
// ============================================================================
interface spi_input_conditioner_if;
    logic sclk_pin;
    logic cs_pin;
    logic mosi_pin;
    logic sclk_cond;
    logic sclk_posedge;
    logic sclk_negedge;
    logic cs_cond;
    logic cs_fall;
    logic cs_rise;
    logic mosi_cond;

    modport master (
        output sclk_pin, cs_pin, mosi_pin,
        input  sclk_cond, sclk_posedge, sclk_negedge,
        input  cs_cond, cs_fall, cs_rise, mosi_cond
    );

    modport slave (
        input  sclk_pin, cs_pin, mosi_pin,
        output sclk_cond, sclk_posedge, sclk_negedge,
        output cs_cond, cs_fall, cs_rise, mosi_cond
    );
endinterface
`default_nettype wire

// File: rtl/spi_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : spi_input_conditioner
// Description : Synchronize, debounce and edge-detect SCLK, CS and MOSI.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_input_conditioner #(
    parameter int COUNTER_WIDTH = 3,
    parameter int WAIT_TIME     = 3
) (
    input  wire logic              clk,
    input  wire logic              reset,
    spi_input_conditioner_if.slave bus
);

    // Channel order is {mosi, cs, sclk}; CS idles high so it resets to 1.
    localparam logic [2:0]               C_RST_LEVEL = 3'b010;
    localparam logic [COUNTER_WIDTH-1:0] C_WAIT      = COUNTER_WIDTH'(WAIT_TIME);

    logic [2:0]                    w_pin;
    logic [2:0]                    w_accept;
    logic [2:0]                    sync0_q;
    logic [2:0]                    sync1_q;
    logic [2:0]                    cond_q;
    logic [2:0][COUNTER_WIDTH-1:0] cnt_q;
    logic [2:0][COUNTER_WIDTH-1:0] cnt_d;
    logic [1:0]                    rise_q;
    logic [1:0]                    fall_q;

    assign w_pin = {bus.mosi_pin, bus.cs_pin, bus.sclk_pin};

    always_comb begin
        w_accept = '0;
        cnt_d    = cnt_q;
        for (int i = 0; i < 3; i++) begin
            if (sync1_q[i] == cond_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == C_WAIT) begin
                w_accept[i] = 1'b1;
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync0_q <= C_RST_LEVEL;
            sync1_q <= C_RST_LEVEL;
            cond_q  <= C_RST_LEVEL;
            cnt_q   <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
        end else begin
            sync0_q <= w_pin;
            sync1_q <= sync0_q;
            cnt_q   <= cnt_d;
            cond_q  <= (cond_q & ~w_accept) | (sync1_q & w_accept);
            // MOSI is level-only, so strobes exist for sclk and cs alone.
            rise_q  <= w_accept[1:0] &  sync1_q[1:0];
            fall_q  <= w_accept[1:0] & ~sync1_q[1:0];
        end
    end

    assign bus.sclk_cond    = cond_q[0];
    assign bus.sclk_posedge = rise_q[0];
    assign bus.sclk_negedge = fall_q[0];
    assign bus.cs_cond      = cond_q[1];
    assign bus.cs_rise      = rise_q[1];
    assign bus.cs_fall      = fall_q[1];
    assign bus.mosi_cond    = cond_q[2];

endmodule
`default_nettype wire
